// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha keystream core: the word type, the sigma
// constants, the FSM encoding, quarter-round index tables and word helpers.
package chacha_pkg;

    typedef logic [31:0] word_t;

    // "expand 32-byte k" as four little-endian words
    localparam word_t SIGMA_0 = 32'h61707865;
    localparam word_t SIGMA_1 = 32'h3320646e;
    localparam word_t SIGMA_2 = 32'h79622d32;
    localparam word_t SIGMA_3 = 32'h6b206574;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    // Quarter-round word indices, one nibble per entry, entry (qr*4+pos)
    // counted from the most significant nibble.
    localparam logic [63:0] COL_TBL  = 64'h048C_159D_26AE_37BF;
    localparam logic [63:0] DIAG_TBL = 64'h05AF_16BC_278D_349E;

    function automatic logic [3:0] qr_index(input logic diag, input logic [1:0] qr,
                                            input logic [1:0] pos);
        logic [63:0] tbl;
        tbl = diag ? DIAG_TBL : COL_TBL;
        return tbl[{~{qr, pos}, 2'b00} +: 4];
    endfunction

    // Word 0 sits in the top 32 bits of a packed 512-bit state.
    function automatic word_t get_word(input logic [511:0] s, input logic [3:0] idx);
        return s[{~idx, 5'd0} +: 32];
    endfunction

    function automatic logic [511:0] put_word(input logic [511:0] s, input logic [3:0] idx,
                                              input word_t w);
        logic [511:0] r;
        r = s;
        r[{~idx, 5'd0} +: 32] = w;
        return r;
    endfunction

    function automatic logic [127:0] quarter_round(input word_t a_in, input word_t b_in,
                                                   input word_t c_in, input word_t d_in);
        word_t a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

endpackage

// File: rtl/chacha_dround.sv
// Combinational ChaCha round function. With one round per cycle i_odd picks
// column (0) or diagonal (1) quarter-rounds; with two rounds per cycle the
// first round follows i_odd and the second takes the opposite parity.
module chacha_dround
    import chacha_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)(
    input  logic [511:0] i_state,
    input  logic         i_odd,
    output logic [511:0] o_state
);

    function automatic logic [511:0] half_round(input logic [511:0] s, input logic diag);
        logic [511:0] r;
        logic [127:0] q;
        logic [3:0]   ia, ib, ic, id;
        r = s;
        for (int n = 0; n < 4; n++) begin
            ia = qr_index(diag, n[1:0], 2'd0);
            ib = qr_index(diag, n[1:0], 2'd1);
            ic = qr_index(diag, n[1:0], 2'd2);
            id = qr_index(diag, n[1:0], 2'd3);
            q  = quarter_round(get_word(r, ia), get_word(r, ib),
                               get_word(r, ic), get_word(r, id));
            r  = put_word(r, ia, q[127:96]);
            r  = put_word(r, ib, q[95:64]);
            r  = put_word(r, ic, q[63:32]);
            r  = put_word(r, id, q[31:0]);
        end
        return r;
    endfunction

    // Apply one or two rounds to the working state
    always_comb begin
        if (ROUNDS_PER_CYCLE == 2) begin
            o_state = half_round(half_round(i_state, i_odd), ~i_odd);
        end else begin
            o_state = half_round(i_state, i_odd);
        end
    end

endmodule

// File: rtl/chacha_stream_core.sv
// ChaCha keystream generator: builds the initial state from key/nonce/counter,
// iterates the round function and emits consecutive 512-bit blocks under
// valid/ready flow control, bumping the block counter between blocks.
// Optional HChaCha subkey mode is compiled in with `define CHACHA_HCHACHA_EN.
module chacha_stream_core
    import chacha_pkg::*;
#(
    parameter int NUM_ROUNDS       = 20,
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int CTR_WIDTH        = 32
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [255:0]           key,
    input  logic [127-CTR_WIDTH:0] nonce,
    input  logic [CTR_WIDTH-1:0]   ctr_init,
    input  logic [15:0]            num_blocks,
    input  logic                   hchacha,
    output logic                   busy,
    output logic                   ks_valid,
    input  logic                   ks_ready,
    output logic [511:0]           ks_data,
    output logic                   ks_last,
    output logic [CTR_WIDTH-1:0]   ctr_out,
    output logic                   done,
    output logic                   err_ctr_wrap
);

    localparam int              CTR_WORDS = CTR_WIDTH / 32;
    localparam int              RCW       = $clog2(NUM_ROUNDS + 1);
    localparam logic [RCW-1:0]  LAST_RND  = RCW'(NUM_ROUNDS - ROUNDS_PER_CYCLE);
    localparam logic [RCW-1:0]  RND_STEP  = RCW'(ROUNDS_PER_CYCLE);

    // Counter words start at word 12, least significant word first.
    function automatic logic [511:0] set_ctr(input logic [511:0] s,
                                             input logic [CTR_WIDTH-1:0] c);
        logic [511:0] r;
        r = s;
        for (int j = 0; j < CTR_WORDS; j++) begin
            r[32*(3-j) +: 32] = c[32*j +: 32];
        end
        return r;
    endfunction

    function automatic logic [511:0] build_state(input logic [255:0] k,
                                                 input logic [127-CTR_WIDTH:0] n,
                                                 input logic [CTR_WIDTH-1:0] c,
                                                 input logic h);
        logic [511:0] s;
        s = {SIGMA_0, SIGMA_1, SIGMA_2, SIGMA_3, k, 128'd0};
        if (h) begin
            s[127:0] = {c, n};
        end else begin
            s[127-CTR_WIDTH:0] = n;
            s = set_ctr(s, c);
        end
        return s;
    endfunction

    function automatic logic [511:0] feed_forward(input logic [511:0] a, input logic [511:0] b);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) begin
            r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
        end
        return r;
    endfunction

    function automatic logic [511:0] hchacha_out(input logic [511:0] w);
        return {w[511:384], w[127:0], 256'd0};
    endfunction

    state_t                r_state;
    logic [511:0]          r_orig;
    logic [511:0]          r_work;
    logic [CTR_WIDTH-1:0]  r_ctr;
    logic [15:0]           r_remaining;
    logic [RCW-1:0]        r_round_cnt;
    logic                  r_hmode;
    logic                  r_ks_valid;
    logic [511:0]          r_ks_data;
    logic                  r_ks_last;
    logic [CTR_WIDTH-1:0]  r_ctr_out;
    logic                  r_done;
    logic                  r_err;

    logic                  w_hmode_req;
    logic [511:0]          w_init;
    logic [511:0]          w_round;
    logic [CTR_WIDTH-1:0]  w_ctr_next;
    logic [511:0]          w_orig_next;

`ifdef CHACHA_HCHACHA_EN
    assign w_hmode_req = hchacha;
`else
    logic w_unused_hchacha;
    assign w_unused_hchacha = hchacha;
    assign w_hmode_req      = 1'b0;
`endif

    assign w_init      = build_state(key, nonce, ctr_init, w_hmode_req);
    assign w_ctr_next  = r_ctr + CTR_WIDTH'(1);
    assign w_orig_next = set_ctr(r_orig, w_ctr_next);

    chacha_dround #(
        .ROUNDS_PER_CYCLE (ROUNDS_PER_CYCLE)
    ) u_dround (
        .i_state (r_work),
        .i_odd   (r_round_cnt[0]),
        .o_state (w_round)
    );

    // Job FSM: load on start, iterate rounds, hold block until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_orig      <= '0;
            r_work      <= '0;
            r_ctr       <= '0;
            r_remaining <= 16'd0;
            r_round_cnt <= '0;
            r_hmode     <= 1'b0;
            r_ks_valid  <= 1'b0;
            r_ks_data   <= '0;
            r_ks_last   <= 1'b0;
            r_ctr_out   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_orig      <= w_init;
                        r_work      <= w_init;
                        r_ctr       <= ctr_init;
                        r_hmode     <= w_hmode_req;
                        r_remaining <= (w_hmode_req || (num_blocks == 16'd0)) ? 16'd1 : num_blocks;
                        r_round_cnt <= '0;
                        r_err       <= 1'b0;
                        r_state     <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_work <= w_round;
                    if (r_round_cnt == LAST_RND) begin
                        r_round_cnt <= '0;
                        r_ks_data   <= r_hmode ? hchacha_out(w_round) : feed_forward(r_orig, w_round);
                        r_ks_valid  <= 1'b1;
                        r_ks_last   <= (r_remaining == 16'd1);
                        r_ctr_out   <= r_ctr;
                        r_state     <= ST_OUT;
                    end else begin
                        r_round_cnt <= r_round_cnt + RND_STEP;
                    end
                end
                ST_OUT: begin
                    if (ks_ready) begin
                        r_ks_valid <= 1'b0;
                        if (r_remaining == 16'd1) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else if (w_ctr_next == '0) begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ctr       <= w_ctr_next;
                            r_orig      <= w_orig_next;
                            r_work      <= w_orig_next;
                            r_remaining <= r_remaining - 16'd1;
                            r_state     <= ST_ROUND;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign ks_valid     = r_ks_valid;
    assign ks_data      = r_ks_data;
    assign ks_last      = r_ks_last;
    assign ctr_out      = r_ctr_out;
    assign done         = r_done;
    assign err_ctr_wrap = r_err;

endmodule

// File: tb/tb_chacha_stream_core.sv
// Testbench for chacha_stream_core against a word-array ChaCha reference model.
module tb_chacha_stream_core;

    localparam int NR  = 20;
    localparam int RPC = 1;
    localparam int CW  = 32;
    localparam int NW  = 128 - CW;
    localparam int LAT = NR / RPC + 1;

    localparam logic [255:0] K_RFC = {32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                      32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
    localparam logic [NW-1:0] N_RFC = {32'h09000000, 32'h4a000000, 32'h00000000};

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [255:0]    key;
    logic [NW-1:0]   nonce;
    logic [CW-1:0]   ctr_init;
    logic [15:0]     num_blocks;
    logic            hchacha;
    logic            busy;
    logic            ks_valid;
    logic            ks_ready;
    logic [511:0]    ks_data;
    logic            ks_last;
    logic [CW-1:0]   ctr_out;
    logic            done;
    logic            err_ctr_wrap;

    always #5 clk = ~clk;

    chacha_stream_core #(
        .NUM_ROUNDS       (NR),
        .ROUNDS_PER_CYCLE (RPC),
        .CTR_WIDTH        (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key          (key),
        .nonce        (nonce),
        .ctr_init     (ctr_init),
        .num_blocks   (num_blocks),
        .hchacha      (hchacha),
        .busy         (busy),
        .ks_valid     (ks_valid),
        .ks_ready     (ks_ready),
        .ks_data      (ks_data),
        .ks_last      (ks_last),
        .ctr_out      (ctr_out),
        .done         (done),
        .err_ctr_wrap (err_ctr_wrap)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    int unsigned mx[16];

    function automatic int unsigned rl(input int unsigned v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function void mqr(input int a, input int b, input int c, input int d);
        mx[a] = mx[a] + mx[b]; mx[d] = rl(mx[d] ^ mx[a], 16);
        mx[c] = mx[c] + mx[d]; mx[b] = rl(mx[b] ^ mx[c], 12);
        mx[a] = mx[a] + mx[b]; mx[d] = rl(mx[d] ^ mx[a], 8);
        mx[c] = mx[c] + mx[d]; mx[b] = rl(mx[b] ^ mx[c], 7);
    endfunction

    function automatic logic [511:0] model_block(input logic [255:0] k, input logic [NW-1:0] n,
                                                 input logic [CW-1:0] c, input bit h);
        int unsigned  s[16];
        logic [127:0] t;
        logic [511:0] o;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[255-32*i -: 32];
        if (h) begin
            t = {c, n};
            for (int m = 0; m < 4; m++) s[12+m] = t[127-32*m -: 32];
        end else begin
            for (int j = 0; j < CW/32; j++) s[12+j] = c[32*j +: 32];
            for (int m = 0; m < NW/32; m++) s[12+CW/32+m] = n[NW-1-32*m -: 32];
        end
        for (int i = 0; i < 16; i++) mx[i] = s[i];
        for (int r = 0; r < NR; r += 2) begin
            mqr(0, 4, 8, 12); mqr(1, 5, 9, 13); mqr(2, 6, 10, 14); mqr(3, 7, 11, 15);
            mqr(0, 5, 10, 15); mqr(1, 6, 11, 12); mqr(2, 7, 8, 13); mqr(3, 4, 9, 14);
        end
        o = '0;
        if (h) begin
            for (int m = 0; m < 4; m++) begin
                o[511-32*m -: 32] = mx[m];
                o[383-32*m -: 32] = mx[12+m];
            end
        end else begin
            for (int i = 0; i < 16; i++) o[511-32*i -: 32] = mx[i] + s[i];
        end
        return o;
    endfunction

    // ---------------- stimulus helpers ----------------
    logic [255:0]  j_key;
    logic [NW-1:0] j_nonce;
    logic [CW-1:0] j_ctr;
    bit            j_h;

    logic [511:0]  cq_data[$];
    logic [CW-1:0] cq_ctr[$];
    logic          cq_last[$];
    int            c_lat, c_done, c_timeout, c_stall_chg;
    logic          c_err1;

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [NW-1:0] rndnonce();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[NW-1:0];
    endfunction

    // Called #1 after a posedge; the next edge samples start.
    task automatic launch(input logic [255:0] k, input logic [NW-1:0] n, input logic [CW-1:0] c,
                          input logic [15:0] nb, input bit h);
        j_key = k; j_nonce = n; j_ctr = c; j_h = h;
        key = k; nonce = n; ctr_init = c; num_blocks = nb; hchacha = h;
        start = 1'b1;
    endtask

    // Runs the launched job, recording accepted blocks; rmode 0 = always ready, 1 = random.
    task automatic collect(input int rmode, input int budget, input int poke);
        logic [511:0] prev_data;
        bit           prev_stall;
        bit           r;
        cq_data.delete(); cq_ctr.delete(); cq_last.delete();
        c_lat = -1; c_done = 0; c_timeout = 1; c_stall_chg = 0; c_err1 = 1'b1;
        prev_stall = 1'b0; prev_data = '0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            key = rnd256(); nonce = rndnonce(); ctr_init = CW'($urandom);
            num_blocks = 16'($urandom); hchacha = 1'($urandom);
            if (cyc == poke) start = 1'b1;
            if (cyc == 1) c_err1 = err_ctr_wrap;
            if (!busy) begin
                c_done = done;
                c_timeout = 0;
                break;
            end
            if (ks_valid) begin
                if (c_lat < 0) c_lat = cyc;
                if (prev_stall && (ks_data !== prev_data)) c_stall_chg++;
                r = (rmode == 0) ? 1'b1 : 1'($urandom);
                if (r) begin
                    cq_data.push_back(ks_data);
                    cq_ctr.push_back(ctr_out);
                    cq_last.push_back(ks_last);
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = ks_data;
                end
                ks_ready = r;
            end else begin
                ks_ready = 1'b0;
            end
        end
        start = 1'b0;
        ks_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ks_ready = 1'b0; key = '0; nonce = '0;
        ctr_init = '0; num_blocks = 16'd0; hchacha = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (ks_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", ks_valid); end
        total++; if (ks_data !== 512'd0) begin bad++; $display("FAIL reset_data got %h want 0", ks_data); end
        total++; if (ks_last !== 1'b0) begin bad++; $display("FAIL reset_last got %b want 0", ks_last); end
        total++; if (ctr_out !== '0) begin bad++; $display("FAIL reset_ctr got %h want 0", ctr_out); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
        total++; if (err_ctr_wrap !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err_ctr_wrap); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rfc_vector(input string tag);
        logic [511:0] exp;
        launch(K_RFC, N_RFC, CW'(1), 16'd1, 1'b0);
        collect(0, 200, 0);
        exp = model_block(K_RFC, N_RFC, CW'(1), 1'b0);
        total++; if (c_timeout !== 0) begin bad++; $display("FAIL %s_timeout got %0d want 0", tag, c_timeout); end
        total++; if (cq_data.size() !== 1) begin bad++; $display("FAIL %s_count got %0d want 1", tag, cq_data.size()); end
        if (cq_data.size() > 0) begin
            total++; if (cq_data[0][511:480] !== 32'he4e7f110) begin bad++; $display("FAIL %s_word0 got %h want e4e7f110", tag, cq_data[0][511:480]); end
            total++; if (cq_data[0][479:448] !== 32'h15593bd1) begin bad++; $display("FAIL %s_word1 got %h want 15593bd1", tag, cq_data[0][479:448]); end
            total++; if (cq_data[0] !== exp) begin bad++; $display("FAIL %s_block got %h want %h", tag, cq_data[0], exp); end
            total++; if (cq_last[0] !== 1'b1) begin bad++; $display("FAIL %s_last got %b want 1", tag, cq_last[0]); end
            total++; if (cq_ctr[0] !== CW'(1)) begin bad++; $display("FAIL %s_ctr got %h want 1", tag, cq_ctr[0]); end
        end
        total++; if (c_lat !== LAT) begin bad++; $display("FAIL %s_latency got %0d want %0d", tag, c_lat, LAT); end
        total++; if (c_done !== 1) begin bad++; $display("FAIL %s_done got %0d want 1", tag, c_done); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse got %b want 0", tag, done); end
    endtask

    task automatic test_multi_block_stall();
        logic [511:0] exp;
        launch(K_RFC, N_RFC, CW'(1), 16'd4, 1'b0);
        collect(1, 3000, 0);
        total++; if (cq_data.size() !== 4) begin bad++; $display("FAIL multi_count got %0d want 4", cq_data.size()); end
        for (int i = 0; i < cq_data.size(); i++) begin
            exp = model_block(K_RFC, N_RFC, CW'(1 + i), 1'b0);
            total++; if (cq_data[i] !== exp) begin bad++; $display("FAIL multi_block%0d got %h want %h", i, cq_data[i], exp); end
            total++; if (cq_ctr[i] !== CW'(1 + i)) begin bad++; $display("FAIL multi_ctr%0d got %h want %h", i, cq_ctr[i], CW'(1 + i)); end
            total++; if (cq_last[i] !== (i == 3)) begin bad++; $display("FAIL multi_last%0d got %b want %b", i, cq_last[i], (i == 3)); end
        end
        total++; if (c_stall_chg !== 0) begin bad++; $display("FAIL multi_stable got %0d changes want 0", c_stall_chg); end
        total++; if (c_done !== 1) begin bad++; $display("FAIL multi_done got %0d want 1", c_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_ctr_wrap();
        logic [511:0]  exp;
        logic [255:0]  k;
        logic [NW-1:0] n;
        k = rnd256(); n = rndnonce();
        launch(k, n, CW'(32'hFFFFFFFE), 16'd4, 1'b0);
        collect(1, 3000, 0);
        total++; if (cq_data.size() !== 2) begin bad++; $display("FAIL wrap_count got %0d want 2", cq_data.size()); end
        for (int i = 0; i < cq_data.size(); i++) begin
            exp = model_block(k, n, CW'(32'hFFFFFFFE) + CW'(i), 1'b0);
            total++; if (cq_data[i] !== exp) begin bad++; $display("FAIL wrap_block%0d got %h want %h", i, cq_data[i], exp); end
            total++; if (cq_ctr[i] !== CW'(32'hFFFFFFFE) + CW'(i)) begin bad++; $display("FAIL wrap_ctr%0d got %h", i, cq_ctr[i]); end
            total++; if (cq_last[i] !== 1'b0) begin bad++; $display("FAIL wrap_last%0d got %b want 0", i, cq_last[i]); end
        end
        total++; if (c_timeout !== 0) begin bad++; $display("FAIL wrap_timeout got %0d want 0", c_timeout); end
        total++; if (c_done !== 0) begin bad++; $display("FAIL wrap_done got %0d want 0", c_done); end
        total++; if (err_ctr_wrap !== 1'b1) begin bad++; $display("FAIL wrap_err got %b want 1", err_ctr_wrap); end
        repeat (3) @(posedge clk);
        #1;
        total++; if ({busy, done, err_ctr_wrap} !== 3'b001) begin bad++; $display("FAIL wrap_after got busy/done/err %b want 001", {busy, done, err_ctr_wrap}); end
        k = rnd256(); n = rndnonce();
        launch(k, n, CW'(7), 16'd1, 1'b0);
        collect(0, 200, 0);
        total++; if (c_err1 !== 1'b0) begin bad++; $display("FAIL wrap_err_clear got %b want 0", c_err1); end
        total++; if (cq_data.size() !== 1) begin bad++; $display("FAIL wrap_restart_count got %0d want 1", cq_data.size()); end
        if (cq_data.size() > 0) begin
            exp = model_block(k, n, CW'(7), 1'b0);
            total++; if (cq_data[0] !== exp) begin bad++; $display("FAIL wrap_restart_block got %h want %h", cq_data[0], exp); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_job();
        int seen;
        launch(rnd256(), rndnonce(), CW'(3), 16'd2, 1'b0);
        repeat (6) begin @(posedge clk); #1; start = 1'b0; end
        rst_n = 1'b0;
        #1;
        total++; if ({busy, ks_valid, ks_last, done, err_ctr_wrap} !== 5'd0) begin bad++; $display("FAIL rst_round_ctl got %b want 0", {busy, ks_valid, ks_last, done, err_ctr_wrap}); end
        total++; if (ks_data !== 512'd0 || ctr_out !== '0) begin bad++; $display("FAIL rst_round_data got %h / %h want 0", ks_data, ctr_out); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        launch(rnd256(), rndnonce(), CW'(9), 16'd3, 1'b0);
        ks_ready = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (ks_valid) begin seen = 1; break; end
        end
        total++; if (seen !== 1) begin bad++; $display("FAIL rst_out_wait got %0d want 1", seen); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (ks_valid !== 1'b1) begin bad++; $display("FAIL rst_out_hold got %b want 1", ks_valid); end
        rst_n = 1'b0;
        #1;
        total++; if ({busy, ks_valid, ks_last, done, err_ctr_wrap} !== 5'd0) begin bad++; $display("FAIL rst_out_ctl got %b want 0", {busy, ks_valid, ks_last, done, err_ctr_wrap}); end
        total++; if (ks_data !== 512'd0 || ctr_out !== '0) begin bad++; $display("FAIL rst_out_data got %h / %h want 0", ks_data, ctr_out); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_rfc_vector("post_rst");
    endtask

    task automatic test_start_while_busy(input int poke);
        logic [511:0] exp;
        logic [CW-1:0] c0;
        c0 = CW'($urandom_range(0, 32'h00FF_FFFF));
        launch(rnd256(), rndnonce(), c0, 16'd2, 1'b0);
        collect(1, 3000, poke);
        total++; if (cq_data.size() !== 2) begin bad++; $display("FAIL busy_start_count got %0d want 2", cq_data.size()); end
        for (int i = 0; i < cq_data.size(); i++) begin
            exp = model_block(j_key, j_nonce, c0 + CW'(i), 1'b0);
            total++; if (cq_data[i] !== exp) begin bad++; $display("FAIL busy_start_block%0d got %h want %h", i, cq_data[i], exp); end
            total++; if (cq_ctr[i] !== c0 + CW'(i)) begin bad++; $display("FAIL busy_start_ctr%0d got %h want %h", i, cq_ctr[i], c0 + CW'(i)); end
        end
        total++; if (c_lat !== LAT) begin bad++; $display("FAIL busy_start_latency got %0d want %0d", c_lat, LAT); end
        @(posedge clk); #1;
    endtask

    task automatic test_random_jobs();
        logic [511:0] exp;
        logic [15:0]  nb;
        int           want;
        bit           h;
        for (int it = 0; it < 6; it++) begin
            nb = 16'($urandom_range(0, 3));
            want = (nb == 16'd0) ? 1 : int'(nb);
`ifdef CHACHA_HCHACHA_EN
            h = 1'b0;
`else
            h = 1'($urandom);
`endif
            launch(rnd256(), rndnonce(), CW'($urandom_range(0, 32'hFFFF0000)), nb, h);
            collect(1, 3000, 0);
            total++; if (cq_data.size() !== want) begin bad++; $display("FAIL rand%0d_count got %0d want %0d", it, cq_data.size(), want); end
            for (int i = 0; i < cq_data.size(); i++) begin
                exp = model_block(j_key, j_nonce, j_ctr + CW'(i), 1'b0);
                total++; if (cq_data[i] !== exp) begin bad++; $display("FAIL rand%0d_block%0d got %h want %h", it, i, cq_data[i], exp); end
                total++; if (cq_ctr[i] !== j_ctr + CW'(i)) begin bad++; $display("FAIL rand%0d_ctr%0d got %h", it, i, cq_ctr[i]); end
                total++; if (cq_last[i] !== (i == want - 1)) begin bad++; $display("FAIL rand%0d_last%0d got %b", it, i, cq_last[i]); end
            end
            total++; if (c_done !== 1) begin bad++; $display("FAIL rand%0d_done got %0d want 1", it, c_done); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hchacha();
        logic [511:0]  exp;
        logic [NW-1:0] n;
        n = {32'h4a000000, 32'h00000000, 32'h27594131};
`ifdef CHACHA_HCHACHA_EN
        launch(K_RFC, n, CW'(32'h09000000), 16'd5, 1'b1);
        collect(0, 200, 0);
        exp = model_block(K_RFC, n, CW'(32'h09000000), 1'b1);
        total++; if (cq_data.size() !== 1) begin bad++; $display("FAIL hchacha_count got %0d want 1", cq_data.size()); end
        if (cq_data.size() > 0) begin
            total++; if (cq_data[0][511:256] !== {32'h423b4182, 32'hfe7bb227, 32'h50420ed3, 32'h737d878a,
                                                  32'hd5e4f9a0, 32'h53a8748a, 32'h13c42ec1, 32'hdcecd326}) begin
                bad++; $display("FAIL hchacha_subkey got %h", cq_data[0][511:256]); end
            total++; if (cq_data[0][255:0] !== 256'd0) begin bad++; $display("FAIL hchacha_low got %h want 0", cq_data[0][255:0]); end
            total++; if (cq_data[0] !== exp) begin bad++; $display("FAIL hchacha_model got %h want %h", cq_data[0], exp); end
            total++; if (cq_last[0] !== 1'b1) begin bad++; $display("FAIL hchacha_last got %b want 1", cq_last[0]); end
        end
        total++; if (c_done !== 1) begin bad++; $display("FAIL hchacha_done got %0d want 1", c_done); end
`else
        launch(K_RFC, n, CW'(32'h09000000), 16'd2, 1'b1);
        collect(0, 200, 0);
        total++; if (cq_data.size() !== 2) begin bad++; $display("FAIL hchacha_off_count got %0d want 2", cq_data.size()); end
        for (int i = 0; i < cq_data.size(); i++) begin
            exp = model_block(K_RFC, n, CW'(32'h09000000) + CW'(i), 1'b0);
            total++; if (cq_data[i] !== exp) begin bad++; $display("FAIL hchacha_off_block%0d got %h want %h", i, cq_data[i], exp); end
        end
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_rfc_vector("rfc");
        test_multi_block_stall();
        test_ctr_wrap();
        test_reset_mid_job();
        test_start_while_busy(7);
        test_start_while_busy(LAT + 1);
        test_random_jobs();
        test_hchacha();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chacha_stream_core.md
Name: chacha_stream_core

Overview:
Parametrised ChaCha keystream generator. It builds the initial state itself from key, nonce and counter, and produces a run of consecutive 512-bit keystream blocks under valid/ready backpressure, incrementing the counter per block. It runs 1 or 2 rounds per cycle and feeds the PIM AES-GCM/ChaCha datapath's XOR stage, which may stall it.

Parameters:
NUM_ROUNDS, 20, total rounds (8/12/20); must be even and divisible by ROUNDS_PER_CYCLE.
ROUNDS_PER_CYCLE, 1, rounds per clock (1 = column or diagonal; 2 = column+diagonal).
CTR_WIDTH, 32, block counter width (32 = RFC 8439 layout; 64 = original DJB layout).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  accepted only when busy=0; samples all job inputs
key  in  256  words 4..11; key[255:224] is word 4
nonce  in  128-CTR_WIDTH  words (12+CTR_WIDTH/32)..15, MSW first
ctr_init  in  CTR_WIDTH  initial counter, word 12 (LSW) / 13
num_blocks  in  16  blocks in job; 0 treated as 1
hchacha  in  1  HChaCha mode (see Optional Feature)
busy  out  1  job in progress
ks_valid  out  1  ks_data valid
ks_ready  in  1  consumer accept
ks_data  out  512  word 0 in [511:480]
ks_last  out  1  with ks_valid: final block of job
ctr_out  out  CTR_WIDTH  counter value used for current ks_data
done  out  1  one-cycle pulse after the last handshake
err_ctr_wrap  out  1  sticky until next accepted start

Behaviour:
- Reset: all outputs 0; FSM IDLE; all state registers 0. Reset mid-job discards the job with no output.
- State: words 0..3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574. Words 4..11 = key. Counter and nonce words as in the Ports list.
- FSM IDLE -> ROUND on start. Load the working and original state, set remaining = max(num_blocks, 1), clear err_ctr_wrap.
- ROUND: round_cnt steps by ROUNDS_PER_CYCLE. Even round index = column QRs (0,4,8,12)(1,5,9,13)(2,6,10,14)(3,7,11,15). Odd = diagonal QRs (0,5,10,15)(1,6,11,12)(2,7,8,13)(3,4,9,14).
- Final ROUND cycle registers ks_data = orig + working (mod 2^32 per word), then the FSM moves to OUT.
- Latency from start to ks_valid: NUM_ROUNDS/ROUNDS_PER_CYCLE + 1 cycles (21 for the defaults).
- OUT: ks_valid=1. ks_data, ks_last and ctr_out stay stable until ks_valid&&ks_ready.
- On handshake with remaining>1: counter += 1 (mod 2^CTR_WIDTH), reload the working state from the updated orig, remaining -= 1, FSM to ROUND. ks_valid drops the next cycle.
- On handshake with remaining==1: FSM to IDLE, done pulses the next cycle, busy drops with done.
- Counter wrap: if a counter increment produces 0 while remaining>1, set err_ctr_wrap and abort to IDLE. No further blocks are issued and done is not pulsed.
- start while busy=1 is ignored.
- busy = (FSM != IDLE).

Optional Feature:
Macro CHACHA_HCHACHA_EN.
- Defined, hchacha=1 at start:
  - words 12..15 = {ctr_init, nonce}, with CTR_WIDTH ignored for layout;
  - no feed-forward;
  - ks_data[511:256] = final words 0..3,12..15 and ks_data[255:0] = 0;
  - exactly one block, ks_last=1, no counter increment, no wrap check.
- Undefined: hchacha is ignored and the normal stream mode always runs.

Decomposition:
- Package chacha_pkg holds:
  - the sigma constants;
  - the word type (32-bit);
  - the FSM state encoding (IDLE/ROUND/OUT);
  - the QR index tables for column and diagonal rounds.
- Sub-module chacha_dround is the combinational column(+diagonal) round function, parametrised by ROUNDS_PER_CYCLE and a parity input; the core instantiates it once.

Test Plan:
- RFC 8439 §2.3.2 vector: key bytes 00..1f (word 4 = 0x03020100), nonce words 0x09000000, 0x4a000000, 0x00000000, ctr_init=1, num_blocks=1, ks_ready=1. Expect ks_data[511:480]=0xe4e7f110 and [479:448]=0x15593bd1, ks_valid 21 cycles after start, ks_last=1, done pulse.
- Same key/nonce with num_blocks=4 and ks_ready toggled 0/1 randomly. Expect 4 blocks with ctr_out 1,2,3,4, data held stable while stalled, each block equal to the single-block run at that counter, ks_last only on the 4th.
- ctr_init=0xFFFFFFFE, num_blocks=4 → blocks at counters FFFFFFFE and FFFFFFFF, then err_ctr_wrap=1, busy=0, no done pulse; a new start clears err.
- ROUNDS_PER_CYCLE=2 and NUM_ROUNDS=8/12 builds: latency 11 (20 rounds at 2/cycle); outputs match the 1-round-per-cycle model.
- rst_n asserted mid-ROUND and mid-OUT with ks_ready=0 → all outputs 0 immediately. A start issued after reset produces the correct vector; start pulsed while busy has no effect.
- CHACHA_HCHACHA_EN with hchacha=1, key 00..1f, 128-bit nonce of draft-irtf-cfrg-xchacha §2.2.1 → ks_data[511:256] equals the published subkey, [255:0]=0.
